alu_wide_seq: RTL and testbench
===============================

Name: alu_wide_seq

Overview:
- Multi-cycle sequencer that performs WORDS*XLEN-bit operations on the single XLEN-bit ALU, one word per clock.
- Issues words LSW first and chains the ALU carry between words.
- Accepts requests on a valid/ready handshake and returns the wide result plus a merged 4-bit status.
- Sits between the execute stage and the ALU instance. It owns the ALU's a/b/c/alu_op inputs for the duration of an operation.

Parameters:
- XLEN, 32, ALU word width in bits.
- WORDS, 2, number of words per operation (>=1). The counter width is clog2(WORDS), minimum 1 bit.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_op  input  3  ALU opcode (`ADD, `SUB, `OR, `AND, `XOR)
- req_a  input  WORDS*XLEN  operand A
- req_b  input  WORDS*XLEN  operand B
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_result  output  WORDS*XLEN  wide result
- rsp_status  output  4  merged status {N,Z,C,V}
- alu_a  output  XLEN  to ALU a
- alu_b  output  XLEN  to ALU b
- alu_c  output  1  to ALU carry/borrow-in
- alu_op  output  3  to ALU op
- alu_status  input  4  from ALU, {N,Z,C,V} = bits [3:0]
- alu_result  input  XLEN  from ALU (combinational)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_status=0, word counter=0, carry register=0. alu_a/alu_b/alu_c are 0 and alu_op=`ADD while in IDLE.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1 (combinational on state).
  - req_valid&req_ready at an edge: latch op, A and B; clear the counter, the carry register and the result register; set the Z accumulator to 1; go to EXEC.
- EXEC:
  - req_ready=0.
  - Drive alu_a = A word[cnt], alu_b = B word[cnt], alu_op = latched op.
  - alu_c = carry register for `ADD/`SUB. alu_c = 0 for every other op, including unlisted codes, which are otherwise sequenced identically.
  - At each edge: store alu_result into result word[cnt]; carry register <= alu_status[1]; Z accumulator <= Zacc & alu_status[2]; cnt <= cnt+1.
  - On the edge capturing word WORDS-1: rsp_status <= {alu_status[3], Zacc & alu_status[2], alu_status[1], alu_status[0]}; rsp_valid <= 1; go to DONE.
  - N, C and V come from the top word only. Z is set only if every word is zero.
- DONE:
  - rsp_valid=1; rsp_result and rsp_status are held stable.
  - On rsp_valid&rsp_ready at an edge: rsp_valid <= 0, go to IDLE. rsp_result/rsp_status keep their last value.
- Latency: accept edge t0 → rsp_valid high after edge t0+WORDS. With immediate rsp_ready, the next accept is possible at edge t0+WORDS+2. There is no pipelining and one request is in flight at most.
- WORDS=1: EXEC lasts one cycle, alu_c=0, and the status is the ALU status unchanged.
- req_valid while busy: ignored (req_ready=0). Request inputs may change freely after acceptance.
- rsp_ready low in DONE: hold indefinitely, no timeout.
- rsp_ready high outside DONE: no effect.
- Reset asserted mid-EXEC or in DONE: immediate return to reset values. The operation is discarded and no response is produced.
- Counter never wraps: the exit occurs at cnt==WORDS-1.

Test Plan (XLEN=32, WORDS=2 unless noted):
1. `ADD A=0x00000000_FFFFFFFF, B=0x1 → rsp_result=0x00000001_00000000, status N=0 Z=0 C=0. alu_c=0 on word0 and 1 on word1. rsp_valid rises after edge t0+2.
2. `ADD A=all ones, B=0x1 → rsp_result=0, status Z=1 C=1 N=0.
3. `XOR A=B=0x12345678_9ABCDEF0 → rsp_result=0, Z=1. alu_c=0 on both words, even with the carry register set by a previous op.
4. `SUB A=0x00000001_00000000, B=0x1 → rsp_result=0x00000000_FFFFFFFF, N=0 Z=0. Word1 is issued with alu_c = word0 alu_status[1].
5. Backpressure: hold rsp_ready=0 for 5 cycles in DONE with req_valid=1 → result and status stable, req_ready=0, no accept. Raise rsp_ready → IDLE next cycle, then the new request is accepted.
6. Pull rst_n low during EXEC word0 → asynchronously rsp_valid=0, req_ready=1, outputs zero. No response after release. WORDS=1 `AND 0xF0F0&0x0FF0 → 0x00F0 after one cycle.

Source files
------------

// File: rtl/alu_wide_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_wide_seq_if                                                            |
// | Request/response handshake and ALU-side bus of the wide-ALU sequencer.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`ifndef ADD
`define ADD 3'd0
`endif
`ifndef SUB
`define SUB 3'd1
`endif
`ifndef OR
`define OR  3'd2
`endif
`ifndef AND
`define AND 3'd3
`endif
`ifndef XOR
`define XOR 3'd4
`endif

interface alu_wide_seq_if #(
  parameter int XLEN  = 32,
  parameter int WORDS = 2
);
  logic                    req_valid;
  logic                    req_ready;
  logic [2:0]              req_op;
  logic [WORDS*XLEN-1:0]   req_a;
  logic [WORDS*XLEN-1:0]   req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [WORDS*XLEN-1:0]   rsp_result;
  logic [3:0]              rsp_status;
  logic [XLEN-1:0]         alu_a;
  logic [XLEN-1:0]         alu_b;
  logic                    alu_c;
  logic [2:0]              alu_op;
  logic [3:0]              alu_status;
  logic [XLEN-1:0]         alu_result;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_status, alu_result,
    input  req_ready, rsp_valid, rsp_result, rsp_status, alu_a, alu_b, alu_c, alu_op
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_status, alu_result,
    output req_ready, rsp_valid, rsp_result, rsp_status, alu_a, alu_b, alu_c, alu_op
  );
endinterface
`default_nettype wire

// File: rtl/alu_wide_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_wide_seq                                                               |
// | Runs WORDS*XLEN-bit operations on one XLEN-bit ALU, LSW first, one word    |
// | per clock, chaining carry/borrow between words.                            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_wide_seq #(
  parameter int XLEN  = 32,
  parameter int WORDS = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  alu_wide_seq_if.slave     bus
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2:0]              r_op;
  logic [WORDS*XLEN-1:0]   r_a;
  logic [WORDS*XLEN-1:0]   r_b;
  logic [WORDS*XLEN-1:0]   r_result;
  logic [CW-1:0]           r_cnt;
  logic                    r_carry;
  logic                    r_zacc;
  logic [3:0]              r_status;
  logic                    r_rsp_valid;

  logic                    w_last;
  logic                    w_arith;
  logic                    w_zacc_nxt;
  logic [31:0]             w_base;

  assign w_last     = (r_cnt == CW'(WORDS - 1));
  assign w_arith    = (r_op == `ADD) || (r_op == `SUB);
  assign w_zacc_nxt = r_zacc & bus.alu_status[2];
  assign w_base     = 32'(r_cnt) * 32'(XLEN);

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_result;
  assign bus.rsp_status = r_status;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ALU inputs are only driven while a word is being issued; zero/ADD otherwise.
  always_comb begin
    w_state_nxt = r_state;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_c   = 1'b0;
    bus.alu_op  = `ADD;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.alu_a  = r_a[w_base +: XLEN];
        bus.alu_b  = r_b[w_base +: XLEN];
        bus.alu_c  = w_arith & r_carry;
        bus.alu_op = r_op;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= `ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_zacc      <= 1'b0;
      r_status    <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op     <= bus.req_op;
            r_a      <= bus.req_a;
            r_b      <= bus.req_b;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b1;
          end
        end
        S_EXEC: begin
          r_result[w_base +: XLEN] <= bus.alu_result;
          r_carry                  <= bus.alu_status[1];
          r_zacc                   <= w_zacc_nxt;
          // Counter parks on the last word; the next accept clears it.
          if (w_last) begin
            r_status    <= {bus.alu_status[3], w_zacc_nxt, bus.alu_status[1], bus.alu_status[0]};
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_wide_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_wide_seq                                                            |
// | Bench for alu_wide_seq with WORDS=2 and WORDS=1 instances and an ALU model.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_alu_wide_seq;

  logic        clk;
  logic        rst_n;
  int          n_vec;
  int          n_err;
  int          sel;
  logic        req_valid_t;
  logic        rsp_ready_t;
  logic [2:0]  op_t;
  logic [63:0] a_t;
  logic [63:0] b_t;

  logic        o_valid;
  logic        o_ready;
  logic        o_alu_c;
  logic [2:0]  o_alu_op;
  logic [31:0] o_alu_a;
  logic [63:0] o_result;
  logic [3:0]  o_status;

  alu_wide_seq_if #(.XLEN(32), .WORDS(2)) bus2 ();
  alu_wide_seq_if #(.XLEN(32), .WORDS(1)) bus1 ();

  alu_wide_seq #(.XLEN(32), .WORDS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  alu_wide_seq #(.XLEN(32), .WORDS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-word ALU: {N,Z,C,V,result}; C is carry-out for ADD, borrow-out for SUB.
  function automatic logic [35:0] alu_word(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic c);
    logic [32:0] s;
    logic [31:0] r;
    logic        cf;
    logic        vf;
    s = '0; r = '0; cf = 1'b0; vf = 1'b0;
    case (op)
      `ADD: begin
        s = {1'b0, a} + {1'b0, b} + {32'b0, c};
        r = s[31:0]; cf = s[32];
        vf = (a[31] == b[31]) && (r[31] != a[31]);
      end
      `SUB: begin
        s = {1'b0, a} - {1'b0, b} - {32'b0, c};
        r = s[31:0]; cf = s[32];
        vf = (a[31] != b[31]) && (r[31] != a[31]);
      end
      `OR:  r = a | b;
      `AND: r = a & b;
      `XOR: r = a ^ b;
      default: r = '0;
    endcase
    return {r[31], (r == 32'd0), cf, vf, r};
  endfunction

  assign {bus2.alu_status, bus2.alu_result} = alu_word(bus2.alu_op, bus2.alu_a, bus2.alu_b, bus2.alu_c);
  assign {bus1.alu_status, bus1.alu_result} = alu_word(bus1.alu_op, bus1.alu_a, bus1.alu_b, bus1.alu_c);

  assign bus2.req_valid = req_valid_t && (sel == 2);
  assign bus1.req_valid = req_valid_t && (sel == 1);
  assign bus2.rsp_ready = rsp_ready_t && (sel == 2);
  assign bus1.rsp_ready = rsp_ready_t && (sel == 1);
  assign bus2.req_op    = op_t;
  assign bus1.req_op    = op_t;
  assign bus2.req_a     = a_t;
  assign bus2.req_b     = b_t;
  assign bus1.req_a     = a_t[31:0];
  assign bus1.req_b     = b_t[31:0];

  always_comb begin
    o_valid  = bus2.rsp_valid;
    o_ready  = bus2.req_ready;
    o_alu_c  = bus2.alu_c;
    o_alu_op = bus2.alu_op;
    o_alu_a  = bus2.alu_a;
    o_result = bus2.rsp_result;
    o_status = bus2.rsp_status;
    if (sel == 1) begin
      o_valid  = bus1.rsp_valid;
      o_ready  = bus1.req_ready;
      o_alu_c  = bus1.alu_c;
      o_alu_op = bus1.alu_op;
      o_alu_a  = bus1.alu_a;
      o_result = {32'b0, bus1.rsp_result};
      o_status = bus1.rsp_status;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wide reference: whole-operand arithmetic, carry-in of word k is the
  // carry/borrow out of the low k words.
  task automatic ref_op(input int w, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res,
                        output logic [3:0] st, output logic [1:0] cin);
    logic [127:0] m, am, bm, s, lm;
    int           top;
    logic         n, z, c, v;
    top = 32 * w - 1;
    m   = (128'd1 << (32 * w)) - 128'd1;
    am  = {64'b0, a} & m;
    bm  = {64'b0, b} & m;
    c = 1'b0; v = 1'b0; s = '0;
    cin = '0;
    case (op)
      `ADD: begin
        s = am + bm;
        c = s[32 * w];
        v = (am[top] == bm[top]) && (s[top] != am[top]);
      end
      `SUB: begin
        s = am - bm;
        c = (am < bm);
        v = (am[top] != bm[top]) && (s[top] != am[top]);
      end
      `OR:  s = am | bm;
      `AND: s = am & bm;
      `XOR: s = am ^ bm;
      default: s = '0;
    endcase
    s = s & m;
    for (int k = 1; k < w; k++) begin
      lm = (128'd1 << (32 * k)) - 128'd1;
      if (op == `ADD) cin[k] = (((am & lm) + (bm & lm)) >> (32 * k)) != 128'd0;
      if (op == `SUB) cin[k] = ((am & lm) < (bm & lm));
    end
    n   = s[top];
    z   = (s == 128'd0);
    res = s[63:0];
    st  = {n, z, c, v};
  endtask

  task automatic run_op(input int w, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int hold);
    logic [63:0] er;
    logic [63:0] wa;
    logic [3:0]  es;
    logic [1:0]  ec;
    int          cyc;
    ref_op(w, op, a, b, er, es, ec);
    sel = w;
    @(negedge clk);
    chk("idle_ready", {63'b0, o_ready}, 64'd1);
    req_valid_t = 1'b1; op_t = op; a_t = a; b_t = b;
    @(posedge clk); #1;
    req_valid_t = 1'b0; op_t = 3'($urandom); a_t = {$urandom, $urandom}; b_t = {$urandom, $urandom};
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      wa = a >> (32 * k);
      chk("alu_a", {32'b0, o_alu_a}, {32'b0, wa[31:0]});
      chk("alu_c", {63'b0, o_alu_c}, {63'b0, ec[k]});
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_valid && cyc < 20);
    chk("latency", 64'(cyc), 64'd1);
    chk("result", o_result, er);
    chk("status", {60'b0, o_status}, {60'b0, es});
    for (int h = 0; h < hold; h++) begin
      req_valid_t = 1'b1; a_t = {$urandom, $urandom};
      @(negedge clk);
      chk("hold_result", o_result, er);
      chk("hold_status", {60'b0, o_status}, {60'b0, es});
      chk("hold_ready", {63'b0, o_ready}, 64'd0);
      chk("hold_valid", {63'b0, o_valid}, 64'd1);
    end
    rsp_ready_t = 1'b1;
    @(posedge clk); #1;
    rsp_ready_t = 1'b0; req_valid_t = 1'b0;
    chk("valid_drop", {63'b0, o_valid}, 64'd0);
    chk("ready_back", {63'b0, o_ready}, 64'd1);
    chk("result_kept", o_result, er);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        saw_valid;
    logic [63:0] ra, rb;
    logic [2:0]  rop;
    n_vec = 0; n_err = 0; sel = 2;
    req_valid_t = 1'b0; rsp_ready_t = 1'b0; op_t = `ADD; a_t = '0; b_t = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_ready", {63'b0, o_ready}, 64'd1);
    chk("rst_valid", {63'b0, o_valid}, 64'd0);
    chk("rst_result", o_result, 64'd0);
    chk("rst_status", {60'b0, o_status}, 64'd0);
    chk("rst_alu_op", {61'b0, o_alu_op}, {61'b0, `ADD});
    @(negedge clk); rst_n = 1'b1;

    run_op(2, `ADD, 64'h00000000_FFFFFFFF, 64'h1, 0);
    run_op(2, `ADD, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 0);
    run_op(2, `XOR, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 0);
    run_op(2, `SUB, 64'h00000001_00000000, 64'h1, 0);
    run_op(2, `ADD, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 5);
    run_op(2, `SUB, 64'h0, 64'h1, 0);

    // Reset mid-operation: discarded, no response afterwards.
    sel = 2;
    @(negedge clk);
    req_valid_t = 1'b1; op_t = `ADD; a_t = 64'h5; b_t = 64'h7;
    @(posedge clk); #1;
    req_valid_t = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'b0, o_valid}, 64'd0);
    chk("mid_rst_ready", {63'b0, o_ready}, 64'd1);
    chk("mid_rst_alu_a", {32'b0, o_alu_a}, 64'd0);
    chk("mid_rst_result", o_result, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | o_valid;
    end
    chk("no_rsp_after_rst", {63'b0, saw_valid}, 64'd0);

    run_op(1, `AND, 64'h0000F0F0, 64'h00000FF0, 0);
    run_op(1, `ADD, 64'hFFFFFFFF, 64'h1, 1);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) ra = '1;
      if ($urandom_range(0, 4) == 0) rb = ra;
      run_op(($urandom_range(0, 3) == 0) ? 1 : 2, rop, ra, rb, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
